muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the general-purpose register file.
- Consumes the two GPR read operands and produces the architectural HI/LO registers for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Drives a busy flag so the pipeline controller can stall MFHI/MFLO and new muldiv instructions until results are ready.

Parameters:
- MUL_LAT, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_LAT, fixed 33 (not overridable): 32 restoring iterations plus 1 sign-fix cycle.

Ports:
- clk_I  input  1  clock; all state changes on the rising edge.
- clr_I  input  1  asynchronous, active-high reset.
- D1_I  input  32  operand A (rs read data): multiplicand or dividend; source for MTHI/MTLO.
- D2_I  input  32  operand B (rt read data): multiplier or divisor.
- Op_I  input  3  operation code (encodings in the shared header).
- Start_I  input  1  issue strobe, sampled on a rising edge.
- Busy_O  output  1  operation in flight.
- Done_O  output  1  one-cycle pulse when HI/LO take a new mult/div result.
- HI_O  output  32  HI register.
- LO_O  output  32  LO register.

Behaviour:
- Reset: while clr_I is high, asynchronously force HI_O=0, LO_O=0, Busy_O=0, Done_O=0 and state IDLE. A reset during an operation aborts it with no partial write.
- States:
  - IDLE: accepts Start_I.
  - MUL: counter runs from MUL_LAT-1 down to 0.
  - DIV: 32 iterations, counter 31 down to 0.
  - FIX: 1 cycle of sign correction and result write.
- IDLE with Start_I=1, sampled at edge T:
  - MULT/MULTU: latch the 64-bit product (signed or unsigned) at T, enter MUL, Busy_O=1 after T. HI/LO={product[63:32],product[31:0]} are written at edge T+MUL_LAT, Busy_O drops and Done_O=1 for the following cycle.
  - DIV/DIVU: latch operand magnitudes (signed) or raw values (unsigned) and sign flags at T, enter DIV. One restoring step per cycle, then FIX. LO=quotient and HI=remainder are written at edge T+33, with Done_O pulsing as for MUL.
  - MTHI: HI<=D1_I at T. MTLO: LO<=D1_I at T. No busy and no Done_O; the unit stays in IDLE.
  - Op 6/7: no operation.
- Start_I while Busy_O=1 is ignored entirely: no queueing, no effect on the operation in flight. The controller stalls instead.
- HI/LO are stable throughout an operation and change only at the single write edge.
- Signed division:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (either signedness): LO=0xFFFFFFFF, HI=D1_I as latched. Latency is still 33.
- Operands are sampled only at T; D1_I/D2_I may change freely afterwards.
- Done_O and Busy_O are never high in the same cycle.

Decomposition:
- Shared MIPS header:
  - Op encodings: OP_MULT=3'd0, OP_MULTU=3'd1, OP_DIV=3'd2, OP_DIVU=3'd3, OP_MTHI=3'd4, OP_MTLO=3'd5.
  - State encodings: IDLE, MUL, DIV, FIX.
- One sub-module, div_core: an unsigned 32-bit restoring divider that takes a load strobe and dividend/divisor and performs one shift-subtract step per cycle. It outputs quotient/remainder after 32 steps. muldiv_unit owns the sign handling, the multiply path, the counters and HI/LO.

Test Plan:
- MULTU, D1=0xFFFFFFFF, D2=0x00000002, MUL_LAT=5 -> Busy_O high 5 cycles; then HI=0x00000001, LO=0xFFFFFFFE, one-cycle Done_O.
- MULT, D1=0xFFFFFFFD (-3), D2=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB after 5 cycles.
- DIV, D1=0xFFFFFFF9 (-7), D2=2 -> Busy_O 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, 100/7 -> LO=14, HI=2.
- DIVU by zero, D1=0x12345678 -> LO=0xFFFFFFFF, HI=0x12345678 after 33 cycles. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI D1=0xA5A5A5A5 in IDLE -> HI=0xA5A5A5A5 one edge later, Busy_O and Done_O stay 0. A second Start_I (MULT) issued mid-DIV -> ignored, DIV result unchanged.
- Assert clr_I asynchronously at cycle 10 of a DIV -> Busy_O, HI, LO go 0 immediately; after release a fresh MULTU 3*4 gives LO=12, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared MIPS muldiv definitions: operation codes, sequencer states and divider sizing.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int DIV_STEPS = 32;
  localparam int DIV_LAT   = DIV_STEPS + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Unsigned 32-bit restoring divider: one shift-subtract step per enabled cycle.
module div_core (
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic [32:0] rem_sh;
  logic        ge;

  assign rem_sh = {rem, quo[31]};
  assign ge     = rem_sh >= {1'b0, dvs};

  // rem stays below dvs, so the 32-bit wrapped subtraction is exact when ge is set
  always_ff @(posedge clk) begin
    if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      quo <= {quo[30:0], ge};
      rem <= ge ? (rem_sh[31:0] - dvs) : rem_sh[31:0];
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit owning the architectural HI/LO registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 5
) (
  input  logic        clk_I,
  input  logic        clr_I,
  input  logic [31:0] D1_I,
  input  logic [31:0] D2_I,
  input  logic [2:0]  Op_I,
  input  logic        Start_I,
  output logic        Busy_O,
  output logic        Done_O,
  output logic [31:0] HI_O,
  output logic [31:0] LO_O
);

  function automatic logic [31:0] fix_sign(input logic [31:0] mag, input logic neg);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

  state_e      state;
  logic [4:0]  cnt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [63:0] prod_p0;
  logic [31:0] d1_p0;
  logic        div0_p0;
  logic        neg_q_p0;
  logic        neg_r_p0;

  logic               issue;
  logic               is_sdiv;
  logic               div_load;
  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] a_mag;
  logic        [31:0] b_mag;
  logic        [31:0] quo;
  logic        [31:0] rem;

  assign issue    = (state == IDLE) && Start_I;
  assign is_sdiv  = (Op_I == OP_DIV);
  assign div_load = issue && ((Op_I == OP_DIV) || (Op_I == OP_DIVU));

  assign a_sx   = {{32{D1_I[31]}}, D1_I};
  assign b_sx   = {{32{D2_I[31]}}, D2_I};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, D1_I} * {32'd0, D2_I};

  assign a_mag = (is_sdiv && D1_I[31]) ? (~D1_I + 32'd1) : D1_I;
  assign b_mag = (is_sdiv && D2_I[31]) ? (~D2_I + 32'd1) : D2_I;

  div_core u_div_core (
    .clk       (clk_I),
    .load      (div_load),
    .step      (state == DIV),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  // Stage p0: operands captured at issue; D1_I/D2_I are free to change afterwards
  always_ff @(posedge clk_I) begin
    if (issue) begin
      prod_p0  <= (Op_I == OP_MULT) ? $unsigned(prod_s) : prod_u;
      d1_p0    <= D1_I;
      div0_p0  <= (D2_I == 32'd0);
      neg_q_p0 <= is_sdiv && (D1_I[31] ^ D2_I[31]);
      neg_r_p0 <= is_sdiv && D1_I[31];
    end
  end

  always_ff @(posedge clk_I or posedge clr_I) begin
    if (clr_I) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start_I) begin
            case (Op_I)
              OP_MULT, OP_MULTU: begin
                state <= MUL;
                cnt   <= 5'(MUL_LAT - 1);
                busy  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                state <= DIV;
                cnt   <= 5'(DIV_STEPS - 1);
                busy  <= 1'b1;
              end
              OP_MTHI: hi <= D1_I;
              OP_MTLO: lo <= D1_I;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cnt == 5'd0) begin
            hi    <= prod_p0[63:32];
            lo    <= prod_p0[31:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DIV: begin
          if (cnt == 5'd0) state <= FIX;
          else             cnt   <= cnt - 5'd1;
        end
        FIX: begin
          hi    <= div0_p0 ? d1_p0 : fix_sign(rem, neg_r_p0);
          lo    <= div0_p0 ? 32'hFFFF_FFFF : fix_sign(quo, neg_q_p0);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy_O = busy;
  assign Done_O = done;
  assign HI_O   = hi;
  assign LO_O   = lo;

endmodule
